// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the alu_seq sequencer.
//   op_e    : command opcodes as encoded on cmdOp
//   state_e : sequencer FSM states
//   ctrl_t  : bundle of the registered ALU control strobes
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_SHR = 2'd2,
    OP_MUL = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_ADD,
    S_MUL_SHIFT,
    S_DONE
  } state_e;

  localparam int unsigned MUL_STEPS      = 8;
  localparam logic [3:0]  MUL_COUNT_INIT = 4'(MUL_STEPS);

  // ALU control lines; bar_* are active-low bus enables.
  typedef struct packed {
    logic bar_e;
    logic bar_s;
    logic trig_c;
    logic trig_s;
    logic sub;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{bar_e: 1'b1, bar_s: 1'b1, trig_c: 1'b0,
                                  trig_s: 1'b0, sub: 1'b0};

endpackage

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external 8-bit ALU.
// Executes ADD / SUB / SHR in one ALU cycle and an 8x8 unsigned MUL as
// eight shift-add iterations (P:Q shift register, M held in breg).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmdValid/cmdReady           command handshake; cmdReady = idle
//   cmdOp, cmdA, cmdB           opcode and operands (MUL: A x B)
//   rspValid/rspReady           response handshake
//   rspHi, rspLo, rspCarry      result and carry / no-borrow / shifted-out bit
//   areg, breg                  ALU operand registers
//   doSubtract                  ALU subtract select
//   assertBarE, assertBarS      active-low ALU sum / shift bus enables
//   triggerC, triggerS          ALU carry / shift flag capture strobes
//   dbus, flagCarry             ALU result bus and carry flag
//
// Build option: define ALU_SEQ_MUL_SKIP_EN to skip the add cycle of MUL
// iterations whose multiplier bit is 0 (latency 8 + popcount(cmdB)).
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmdOp,
  input  logic [7:0] cmdA,
  input  logic [7:0] cmdB,
  output logic       rspValid,
  input  logic       rspReady,
  output logic [7:0] rspHi,
  output logic [7:0] rspLo,
  output logic       rspCarry,
  output logic [7:0] areg,
  output logic [7:0] breg,
  output logic       doSubtract,
  output logic       assertBarE,
  output logic       assertBarS,
  output logic       triggerC,
  output logic       triggerS,
  input  logic [7:0] dbus,
  input  logic       flagCarry
);

  state_e     r_state, w_state_nxt, w_mul_step;
  op_e        r_op, w_cmd_op;
  ctrl_t      r_ctrl, w_ctrl_nxt;
  logic [7:0] r_areg, r_breg, r_q, r_pn, r_rsp_hi, r_rsp_lo;
  logic       r_c, r_rsp_carry;
  logic [3:0] r_count, w_count_dec;
  logic [7:0] w_pn_eff, w_p_shift, w_q_shift;
  logic       w_c_eff, w_last_step, w_q_lsb_nxt;

  assign w_cmd_op = op_e'(cmdOp);

  // A skipped or non-adding iteration shifts P itself with C=0; only an
  // iteration whose multiplier bit is 1 uses the captured ALU sum.
  assign w_pn_eff    = r_q[0] ? r_pn : r_areg;
  assign w_c_eff     = r_q[0] & r_c;
  assign w_p_shift   = {w_c_eff, w_pn_eff[7:1]};
  assign w_q_shift   = {w_pn_eff[0], r_q[7:1]};
  assign w_count_dec = r_count - 4'd1;
  assign w_last_step = (w_count_dec == 4'd0);

  // Multiplier bit that will sit in Q[0] during the next MUL state.
  assign w_q_lsb_nxt = (r_state == S_IDLE) ? cmdB[0] : r_q[1];

`ifdef ALU_SEQ_MUL_SKIP_EN
  assign w_mul_step = w_q_lsb_nxt ? S_MUL_ADD : S_MUL_SHIFT;
`else
  assign w_mul_step = S_MUL_ADD;
`endif

  // State register and registered controls.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (reset) begin
      r_state <= S_IDLE;
      r_ctrl  <= CTRL_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (cmdValid) w_state_nxt = (w_cmd_op == OP_MUL) ? w_mul_step : S_EXEC;
      S_EXEC:      w_state_nxt = S_DONE;
      S_MUL_ADD:   w_state_nxt = S_MUL_SHIFT;
      S_MUL_SHIFT: w_state_nxt = w_last_step ? S_DONE : w_mul_step;
      S_DONE:      if (rspReady) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Control values for the state being entered, so they are registered and
  // stable for that whole state. EXEC is only ever entered from IDLE.
  always_comb begin
    w_ctrl_nxt = CTRL_IDLE;
    unique case (w_state_nxt)
      S_EXEC: begin
        unique case (w_cmd_op)
          OP_ADD: begin w_ctrl_nxt.bar_e = 1'b0; w_ctrl_nxt.trig_c = 1'b1; end
          OP_SUB: begin
            w_ctrl_nxt.bar_e  = 1'b0;
            w_ctrl_nxt.trig_c = 1'b1;
            w_ctrl_nxt.sub    = 1'b1;
          end
          OP_SHR: begin w_ctrl_nxt.bar_s = 1'b0; w_ctrl_nxt.trig_s = 1'b1; end
          default: w_ctrl_nxt = CTRL_IDLE;
        endcase
      end
      S_MUL_ADD: begin
        if (w_q_lsb_nxt) begin
          w_ctrl_nxt.bar_e  = 1'b0;
          w_ctrl_nxt.trig_c = 1'b1;
        end
      end
      default: w_ctrl_nxt = CTRL_IDLE;
    endcase
  end

  // Datapath: operands, P/Q/C/count, response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_ADD;
      r_areg      <= '0;
      r_breg      <= '0;
      r_q         <= '0;
      r_pn        <= '0;
      r_c         <= 1'b0;
      r_count     <= '0;
      r_rsp_hi    <= '0;
      r_rsp_lo    <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmdValid) begin
            r_op <= w_cmd_op;
            if (w_cmd_op == OP_MUL) begin
              r_areg  <= '0;
              r_breg  <= cmdA;
              r_q     <= cmdB;
              r_count <= MUL_COUNT_INIT;
            end else begin
              r_areg <= cmdA;
              r_breg <= cmdB;
            end
          end
        end
        S_EXEC: begin
          r_rsp_lo    <= dbus;
          r_rsp_hi    <= '0;
          r_rsp_carry <= (r_op == OP_SHR) ? r_areg[0] : flagCarry;
        end
        S_MUL_ADD: begin
          if (r_q[0]) begin
            r_pn <= dbus;
            r_c  <= flagCarry;
          end
        end
        S_MUL_SHIFT: begin
          r_areg  <= w_p_shift;
          r_q     <= w_q_shift;
          r_count <= w_count_dec;
          if (w_last_step) begin
            r_rsp_hi    <= w_p_shift;
            r_rsp_lo    <= w_q_shift;
            r_rsp_carry <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmdReady   = (r_state == S_IDLE);
  assign rspValid   = (r_state == S_DONE);
  assign rspHi      = r_rsp_hi;
  assign rspLo      = r_rsp_lo;
  assign rspCarry   = r_rsp_carry;
  assign areg       = r_areg;
  assign breg       = r_breg;
  assign doSubtract = r_ctrl.sub;
  assign assertBarE = r_ctrl.bar_e;
  assign assertBarS = r_ctrl.bar_s;
  assign triggerC   = r_ctrl.trig_c;
  assign triggerS   = r_ctrl.trig_s;

endmodule
